// File: rtl/post_switch_ctrl_pkg.sv
// Shared types and helpers for the post_switch path sequencer.
// Holds FSM state encoding and counter width rules.
package post_switch_ctrl_pkg;

  localparam int ST_W   = 2;
  localparam int IDLE_W = 8;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd2;

  typedef enum logic [ST_W-1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD
  } state_t;

  // Width able to hold values 0..n-1, never below one bit.
  function automatic int cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gmii_gap_detect.sv
// Inter-frame gap detector on a GMII data-valid stream.
// Ports: clk, rst (sync high), up_dv, gap[7:0] in; gap_ok out.
module gmii_gap_detect
  import post_switch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              up_dv,
  input  logic [IDLE_W-1:0] gap,
  output logic              gap_ok
);

  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (up_dv) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // idle_cnt counts earlier idle cycles, so this cycle is idle
  // number idle_cnt+1; extra bit keeps gap=0 and 255 well behaved.
  assign gap_ok = !up_dv &&
    (({1'b0, idle_cnt} + 9'd1) >= {1'b0, gap});

endmodule

// File: rtl/post_switch_ctrl.sv
// Applies path requests to post_switch.select at frame gaps,
// with post-switch hold-off and a forced switch on timeout.
// Ports: clk, rst (sync high), speed, req_select, up_dv in;
//        select, busy, switch_done, timeout_err, switch_cnt[7:0] out.
module post_switch_ctrl
  import post_switch_ctrl_pkg::*;
#(
  parameter int GAP_1G      = 12,
  parameter int GAP_100M    = 24,
  parameter int HOLD_CYCLES = 64,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       speed,
  input  logic       req_select,
  input  logic       up_dv,
  output logic       select,
  output logic       busy,
  output logic       switch_done,
  output logic       timeout_err,
  output logic [7:0] switch_cnt
);

  localparam int WAIT_W = cnt_w(TIMEOUT);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES + 1);

  localparam logic [IDLE_W-1:0] G1 = IDLE_W'(GAP_1G);
  localparam logic [IDLE_W-1:0] G100 = IDLE_W'(GAP_100M);
  localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] H_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDLE_W-1:0] gap;
  logic              gap_ok;

  assign gap  = speed ? G1 : G100;
  assign busy = (state != IDLE);

  gmii_gap_detect u_gap (
    .clk    (clk),
    .rst    (rst),
    .up_dv  (up_dv),
    .gap    (gap),
    .gap_ok (gap_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      select      <= 1'b0;
      switch_done <= 1'b0;
      timeout_err <= 1'b0;
      switch_cnt  <= '0;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      switch_done <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (req_select != select) state <= WAIT;
        end
        WAIT: begin
          if (req_select == select) begin
            state <= IDLE;
          end else if (gap_ok || wait_cnt == W_LAST) begin
            select      <= req_select;
            switch_cnt  <= switch_cnt + 8'd1;
            hold_cnt    <= '0;
            switch_done <= 1'b1;
            timeout_err <= !gap_ok;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == H_LAST) state <= IDLE;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_post_switch_ctrl.sv
// Self-checking bench for post_switch_ctrl: cycle model plus
// directed frame/gap/hold/timeout/reset scenarios.
module tb_post_switch_ctrl;

  localparam int HOLD = 64;
  localparam int TMO  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       speed = 1'b1;
  logic       req_select = 1'b0;
  logic       up_dv = 1'b0;
  logic       select;
  logic       busy;
  logic       switch_done;
  logic       timeout_err;
  logic [7:0] switch_cnt;

  post_switch_ctrl #(
    .GAP_1G(12), .GAP_100M(24),
    .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .speed(speed),
    .req_select(req_select), .up_dv(up_dv),
    .select(select), .busy(busy),
    .switch_done(switch_done), .timeout_err(timeout_err),
    .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int n_done = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting, 2 holding.
  // Uses the length of the current idle run and how many wait /
  // hold cycles have elapsed, in plain integers.
  int m_phase = 0;
  int m_run = 0;
  int m_wait_len = 0;
  int m_hold_left = 0;
  int m_sel = 0;
  int m_cnt = 0;
  int m_done = 0;
  int m_to = 0;

  always @(posedge clk) begin
    int run_now, gap;
    bit met;
    cyc++;
    if (rst) begin
      m_phase = 0; m_run = 0; m_wait_len = 0;
      m_hold_left = 0; m_sel = 0; m_cnt = 0;
      m_done = 0; m_to = 0;
    end else begin
      run_now = up_dv ? 0 : m_run + 1;
      gap = speed ? 12 : 24;
      met = (run_now >= gap);
      m_done = 0;
      m_to = 0;
      if (m_phase == 0) begin
        m_wait_len = 0;
        if (int'(req_select) != m_sel) m_phase = 1;
      end else if (m_phase == 1) begin
        m_wait_len++;
        if (int'(req_select) == m_sel) begin
          m_phase = 0;
        end else if (met || m_wait_len == TMO) begin
          m_sel = int'(req_select);
          m_cnt = (m_cnt + 1) % 256;
          m_done = 1;
          m_to = met ? 0 : 1;
          m_phase = 2;
          m_hold_left = HOLD;
        end
      end else begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = 0;
      end
      m_run = (run_now > 255) ? 255 : run_now;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_select", int'(select), m_sel);
      chk("m_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("m_done", int'(switch_done), m_done);
      chk("m_timeout", int'(timeout_err), m_to);
      chk("m_cnt", int'(switch_cnt), m_cnt);
      if (switch_done) n_done++;
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (switch_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  // Frame of len cycles; req changes at byte t_req, reverts at
  // t_back, speed drops to 100M at t_spd (negative = never).
  task automatic frame(int len, int t_req, int t_back, int t_spd);
    logic orig;
    orig = req_select;
    up_dv = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == t_req) req_select = ~orig;
      if (i == t_back) req_select = orig;
      if (i == t_spd) speed = 1'b0;
      @(negedge clk);
    end
    up_dv = 1'b0;
  endtask

  initial begin
    int d1, d2, w, c0;
    // reset
    cycles(3);
    chk("rst_select", int'(select), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(switch_cnt), 0);
    rst = 1'b0;
    cycles(30);

    // idle line, best-case switch two cycles after request
    req_select = 1'b1;
    @(negedge clk);
    chk("t1_busy", int'(busy), 1);
    chk("t1_sel_early", int'(select), 0);
    @(negedge clk);
    chk("t1_select", int'(select), 1);
    chk("t1_done", int'(switch_done), 1);
    chk("t1_cnt", int'(switch_cnt), 1);
    chk("t1_tmo", int'(timeout_err), 0);
    d1 = cyc;
    cycles(80);

    // 1G frame, request at byte 40: switch on 12th idle cycle
    frame(128, 40, -1, -1);
    chk("t2_midframe_sel", int'(select), 1);
    chk("t2_busy", int'(busy), 1);
    cycles(11);
    chk("t2_idle11_sel", int'(select), 1);
    @(negedge clk);
    chk("t2_idle12_sel", int'(select), 0);
    chk("t2_done", int'(switch_done), 1);
    chk("t2_cnt", int'(switch_cnt), 2);
    cycles(80);

    // speed drops to 100M while waiting: switch on 24th idle
    frame(128, 40, -1, 100);
    cycles(23);
    chk("t3_idle23_sel", int'(select), 0);
    @(negedge clk);
    chk("t3_idle24_sel", int'(select), 1);
    chk("t3_cnt", int'(switch_cnt), 3);
    speed = 1'b1;
    cycles(80);

    // request withdrawn inside a frame
    c0 = n_done;
    frame(128, 40, 60, -1);
    cycles(40);
    chk("t4_busy", int'(busy), 0);
    chk("t4_cnt", int'(switch_cnt), 3);
    chk("t4_no_pulse", n_done, c0);
    chk("t4_select", int'(select), 1);

    // second request during hold-off
    req_select = 1'b0;
    wait_done(10, d1);
    cycles(10);
    req_select = 1'b1;
    wait_done(200, d2);
    chk("t5_spacing_ok", (d2 - d1 >= HOLD + 2) ? 1 : 0, 1);
    chk("t5_spacing", d2 - d1, 66);
    chk("t5_cnt", int'(switch_cnt), 5);
    cycles(80);

    // continuous data: forced switch after TMO wait cycles
    up_dv = 1'b1;
    req_select = 1'b0;
    w = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        w = cyc;
        break;
      end
    end
    if (w < 0) chk("t6_busy_rise", 0, 1);
    wait_done(TMO + 10, d1);
    chk("t6_wait_len", d1 - w, TMO);
    chk("t6_tmo", int'(timeout_err), 1);
    chk("t6_select", int'(select), 0);
    chk("t6_cnt", int'(switch_cnt), 6);
    cycles(80);

    // reset in the middle of a wait
    req_select = 1'b1;
    cycles(100);
    chk("t7_busy_pre", int'(busy), 1);
    rst = 1'b1;
    cycles(2);
    chk("t7_select", int'(select), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_done", int'(switch_done), 0);
    chk("t7_tmo", int'(timeout_err), 0);
    chk("t7_cnt", int'(switch_cnt), 0);
    rst = 1'b0;
    up_dv = 1'b0;
    wait_done(40, d2);
    chk("t7_reeval_sel", int'(select), 1);
    chk("t7_reeval_cnt", int'(switch_cnt), 1);
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
